// File: rtl/and3_selftest_seq_if.sv
// Interface bundle between the AND3 self-test sequencer and the gate it exercises.
// The master side (sequencer) drives the gate inputs and the sweep status.
// The slave side (gate/bench) provides start and gate_out.
interface and3_selftest_seq_if;
    logic       start;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] fail_vec;
    logic [2:0] dbg_state;

    modport master (
        input  start, gate_out,
        output in1, in2, in3, busy, done, pass, err_count, fail_valid, fail_vec, dbg_state
    );

    modport slave (
        output start, gate_out,
        input  in1, in2, in3, busy, done, pass, err_count, fail_valid, fail_vec, dbg_state
    );
endinterface

// File: rtl/and3_selftest_seq.sv
// Self-test sequencer for a delayed 3-input AND gate.
// Sweeps vectors 000..111 onto the gate, holds each for SETTLE_CYCLES before
// sampling gate_out, and reports error count, first failing vector and pass.
// Status flags (busy/done/pass) are registered from the FSM state, so they
// trail the state by one edge: done rises 1+8*(2+SETTLE_CYCLES) edges after start.
module and3_selftest_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    and3_selftest_seq_if.master  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic [3:0] r_err_count;
    logic       r_fail_valid;
    logic [2:0] r_fail_vec;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic       w_expected;
    logic       w_mismatch;
    logic       w_launch;

    // Reference AND of the current vector and the comparison against the gate.
    assign w_expected = &r_vec;
    assign w_mismatch = (bus.gate_out != w_expected);
    // A new sweep is accepted only when no sweep is running.
    assign w_launch   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Sweep FSM with vector counter, settle counter and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec        <= 3'd0;
            r_cnt        <= 4'd0;
            r_err_count  <= 4'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_vec        <= 3'd0;
                        r_err_count  <= 4'd0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= 3'd0;
                        r_state      <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        // At most 8 vectors, so the 4-bit count cannot overflow.
                        r_err_count <= r_err_count + 4'd1;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_vec   <= r_vec;
                        end
                    end
                    if (r_vec == 3'd7) begin
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_state <= S_APPLY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered status flags derived from the state; cleared on a new launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
            if (w_launch) begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_pass <= (r_err_count == 4'd0);
            end else begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end
        end
    end

    assign bus.in1        = r_vec[2];
    assign bus.in2        = r_vec[1];
    assign bus.in3        = r_vec[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_and3_selftest_seq.sv
// Bench for the AND3 self-test sequencer: two instances (settle 2 and 1),
// selectable gate models, table-driven sweeps plus restart/reset sequences.
module tb_and3_selftest_seq;

    localparam int MODE_IDEAL  = 0;
    localparam int MODE_STUCK0 = 1;
    localparam int MODE_STUCK1 = 2;
    localparam int MODE_NAND   = 3;

    typedef struct {
        int         mode;
        logic [3:0] exp_err;
        logic       exp_fv;
        logic [2:0] exp_fvec;
        logic       exp_pass;
    } sweep_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   mode0  = MODE_IDEAL;
    int   mode1  = MODE_IDEAL;

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic a, input logic b, input logic c);
        case (m)
            MODE_STUCK0: return 1'b0;
            MODE_STUCK1: return 1'b1;
            MODE_NAND:   return ~(a & b & c);
            default:     return a & b & c;
        endcase
    endfunction

    and3_selftest_seq_if if0 ();
    and3_selftest_seq_if if1 ();

    assign if0.gate_out = gate_model(mode0, if0.in1, if0.in2, if0.in3);
    assign if1.gate_out = gate_model(mode1, if1.in1, if1.in2, if1.in3);

    and3_selftest_seq #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    and3_selftest_seq #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    // {in1,in2,in3, busy, done, pass, err_count[3:0], fail_valid, fail_vec[2:0]}
    function automatic logic [13:0] get_outs(input int d);
        if (d == 0)
            return {if0.in1, if0.in2, if0.in3, if0.busy, if0.done, if0.pass,
                    if0.err_count, if0.fail_valid, if0.fail_vec};
        else
            return {if1.in1, if1.in2, if1.in3, if1.busy, if1.done, if1.pass,
                    if1.err_count, if1.fail_valid, if1.fail_vec};
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) if0.start = v;
        else        if1.start = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full sweep on instance d with settle s; extra_at>=0 re-pulses start
    // at that cycle of the sweep (must be ignored).
    task automatic do_sweep(input int d, input int s, input sweep_t t, input int extra_at);
        int          per;
        int          last;
        int          bad_vec;
        int          bad_busy;
        int          bad_done;
        logic [2:0]  exp_vec;
        logic        exp_busy;
        logic        exp_done;
        logic [13:0] o;
        per  = 2 + s;
        last = 8 * per + 1;
        bad_vec  = 0;
        bad_busy = 0;
        bad_done = 0;
        if (d == 0) mode0 = t.mode;
        else        mode1 = t.mode;
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);             // edge k
        #1 set_start(d, 1'b0);
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);         // state after edge k+n
            o        = get_outs(d);
            exp_vec  = (n / per >= 7) ? 3'd7 : 3'(n / per);
            exp_busy = (n >= 1) && (n <= 8 * per);
            exp_done = (n == last);
            if (o[13:11] !== exp_vec)  bad_vec++;
            if (o[10]    !== exp_busy) bad_busy++;
            if (o[9]     !== exp_done) bad_done++;
            set_start(d, (n == extra_at) ? 1'b1 : 1'b0);
            @(posedge clk);
        end
        set_start(d, 1'b0);
        @(negedge clk);
        o = get_outs(d);
        check($sformatf("in_sequence d%0d m%0d", d, t.mode), bad_vec, 0);
        check($sformatf("busy_window d%0d m%0d", d, t.mode), bad_busy, 0);
        check($sformatf("done_timing d%0d m%0d", d, t.mode), bad_done, 0);
        check($sformatf("err_count d%0d m%0d", d, t.mode), o[7:4], t.exp_err);
        check($sformatf("fail_valid d%0d m%0d", d, t.mode), o[3], t.exp_fv);
        check($sformatf("fail_vec d%0d m%0d", d, t.mode), o[2:0], t.exp_fvec);
        check($sformatf("pass d%0d m%0d", d, t.mode), o[8], t.exp_pass);
    endtask

    initial begin
        sweep_t tbl[5];
        sweep_t ideal;
        int     bad;
        tbl[0] = '{MODE_IDEAL,  4'd0, 1'b0, 3'b000, 1'b1};
        tbl[1] = '{MODE_STUCK0, 4'd1, 1'b1, 3'b111, 1'b0};
        tbl[2] = '{MODE_STUCK1, 4'd7, 1'b1, 3'b000, 1'b0};
        tbl[3] = '{MODE_NAND,   4'd8, 1'b1, 3'b000, 1'b0};
        tbl[4] = '{MODE_IDEAL,  4'd0, 1'b0, 3'b000, 1'b1};
        ideal  = tbl[0];

        // Reset block.
        rst = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", get_outs(0), 14'd0);
        check("reset_state", if0.dbg_state, 3'd0);
        rst = 1'b0;

        // Sweeps back to back; each restart is launched from DONE.
        for (int i = 0; i < 5; i++) begin
            do_sweep(0, 2, tbl[i], -1);
        end

        // Second start mid-sweep must not disturb timing or results.
        do_sweep(0, 2, ideal, 10);

        // Reset mid-sweep, with a simultaneous start that must lose to reset.
        @(negedge clk);
        set_start(0, 1'b1);
        @(posedge clk);
        #1 set_start(0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rst_outputs", get_outs(0), 14'd0);
        check("rst_state", if0.dbg_state, 3'd0);
        rst = 1'b0;
        set_start(0, 1'b0);
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) bad++;
        end
        check("idle_after_rst", bad, 0);

        // Shortest settle time on the second instance.
        do_sweep(1, 1, ideal, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/and3_selftest_seq.md
Name: and3_selftest_seq

Overview:
- Upstream stimulus and checker stage for the delayed 3-input AND gate (AND_T_3t).
- Drives all 8 input combinations into the gate and waits a programmable settle time so the gate delay resolves.
- Samples the gate output, compares it against the expected AND, and reports the pass/fail result, error count and first failing vector.
- Instantiated beside the gate in lab benches and on the board top level.

Parameters:
- SETTLE_CYCLES, 2, number of clock cycles the vector is held before gate_out is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to run a full sweep.
- in1  output  1  gate input 1 = vec[2], registered.
- in2  output  1  gate input 2 = vec[1], registered.
- in3  output  1  gate input 3 = vec[0], registered.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high while a sweep runs.
- done  output  1  high once a sweep completes; held until the next start or rst.
- pass  output  1  valid when done=1; high when err_count==0.
- err_count  output  4  number of mismatching vectors, range 0..8.
- fail_valid  output  1  high once any mismatch is recorded in the current sweep.
- fail_vec  output  3  first vector that mismatched; valid when fail_valid=1.

Behaviour:
- Single clock domain is clk. Reset is synchronous and active-high on rst. On the clock edge where rst=1, every output goes to 0 and the state goes to IDLE. This includes in1..in3, busy, done, pass, err_count, fail_valid and fail_vec.
- Internal registers:
  - vec (3b);
  - settle counter cnt (4b);
  - FSM with states IDLE, APPLY, SETTLE, CHECK, DONE.
- in1..in3 always reflect the registered vec.
- IDLE: busy=0, done=0.
  - start=1: vec<=0, err_count<=0, fail_valid<=0, fail_vec<=0, done<=0, pass<=0, go to APPLY.
- APPLY (busy=1): vec is on the gate inputs. cnt<=0, go to SETTLE.
- SETTLE (busy=1): cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to CHECK.
  - This gives exactly SETTLE_CYCLES cycles in SETTLE.
- CHECK (busy=1): expected = vec[2]&vec[1]&vec[0].
  - gate_out!=expected: err_count<=err_count+1 (no overflow possible, maximum is 8).
  - Mismatch with fail_valid==0: fail_vec<=vec and fail_valid<=1. Later mismatches do not overwrite fail_vec.
  - vec==7: go to DONE. Otherwise vec<=vec+1 and go to APPLY. vec never wraps within a sweep.
- DONE: busy=0, done=1, pass=(err_count==0).
  - Inputs stay at vector 7.
  - start=1 restarts exactly as from IDLE; done drops on that edge.
- Latency: each vector takes 2+SETTLE_CYCLES cycles.
  - With start sampled at edge k, done rises at edge k+1+8*(2+SETTLE_CYCLES).
  - With the default SETTLE_CYCLES=2, that is edge k+33.
- start while busy=1 is ignored; the sweep continues unchanged.
- rst=1 mid-sweep aborts immediately to the reset values. A start in the same cycle is ignored because rst has priority.
- gate_out is sampled only in CHECK; glitches during APPLY/SETTLE are not observed.
- The clock period must exceed the gate delay (1 ns). SETTLE_CYCLES≥1 guarantees one full period of settling.

Test Plan:
1. Ideal gate model, SETTLE_CYCLES=2, pulse start -> busy for 32 cycles; done=1 at edge k+33; pass=1, err_count=0, fail_valid=0; in1..in3 visit 000..111 in order, each held 4 cycles.
2. gate_out stuck at 0 -> done=1, pass=0, err_count=1, fail_valid=1, fail_vec=3'b111.
3. gate_out stuck at 1 -> err_count=7, fail_vec=3'b000, pass=0.
4. Inverted gate (NAND) -> err_count=8 (4'b1000), fail_vec=3'b000; then a second start in DONE -> counters clear and a fresh sweep with an ideal gate gives pass=1.
5. Pulse start, then start again at cycle 10 of the sweep; then rst=1 at cycle 20 of a new sweep:
   - The extra start has no effect and done still occurs at edge k+33.
   - The rst gives all outputs 0 and state IDLE on the next edge.
   - No done pulse appears until a new start.
6. SETTLE_CYCLES=1, ideal gate -> each vector held 3 cycles; done at edge k+25; pass=1.
